// File: rtl/emergency_preempt.sv
// Emergency-vehicle pre-emption controller: grants one approach direction at a
// time, separated by an all-red clearance, with round-robin fairness between directions.
module emergency_preempt #(
    parameter int NUM_DIR       = 4,
    parameter int LANES_PER_DIR = 2,
    parameter int CLEAR_CYCLES  = 3,
    parameter int HOLD_CYCLES   = 8,
    parameter int MAX_GRANT     = 32,
    parameter int CNT_W         = 8,
    localparam int NLANE        = NUM_DIR * LANES_PER_DIR,
    localparam int DIR_W        = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:NLANE-1] emergencyLane,
    output logic [0:NLANE-1] laneOutput,
    output logic [0:DIR_W-1] grantDir,
    output logic             preemptActive,
    output logic             clearing
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_GRANT - 1);
    localparam logic [CNT_W-1:0] MAX_SAT    = CNT_W'(MAX_GRANT);
    localparam logic [DIR_W-1:0] LAST_INIT  = DIR_W'(NUM_DIR - 1);

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [0:NLANE-1] reqReg;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] nextTimer;
    logic [DIR_W-1:0] grantSel;
    logic [DIR_W-1:0] nextGrant;
    logic [DIR_W-1:0] lastDir;
    logic [DIR_W-1:0] nextLast;

    logic [NUM_DIR-1:0] dirReq;
    logic [DIR_W-1:0]   idleWinner;
    logic               idleFound;
    logic [DIR_W-1:0]   grantWinner;
    logic               grantFound;
    logic               curReq;
    logic               holdDone;
    logic               maxDone;

    // A direction requests if any of its lanes does; lanes of one direction are interchangeable.
    always_comb begin
        dirReq = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            for (int l = 0; l < LANES_PER_DIR; l++) begin
                if (reqReg[d * LANES_PER_DIR + l]) begin
                    dirReq[d] = 1'b1;
                end
            end
        end
    end

    // Two round-robin searches: one from lastDir+1 for leaving IDLE, and one from
    // grantDir+1 that skips the current grant for leaving GRANT.
    always_comb begin
        int idx;
        idx         = 0;
        idleWinner  = '0;
        idleFound   = 1'b0;
        grantWinner = '0;
        grantFound  = 1'b0;
        for (int i = 0; i < NUM_DIR; i++) begin
            idx = int'(lastDir) + 1 + i;
            if (idx >= NUM_DIR) begin
                idx = idx - NUM_DIR;
            end
            if (!idleFound && dirReq[idx]) begin
                idleWinner = DIR_W'(idx);
                idleFound  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_DIR; i++) begin
            idx = int'(grantSel) + 1 + i;
            if (idx >= NUM_DIR) begin
                idx = idx - NUM_DIR;
            end
            if (!grantFound && dirReq[idx] && (DIR_W'(idx) != grantSel)) begin
                grantWinner = DIR_W'(idx);
                grantFound  = 1'b1;
            end
        end
    end

    assign curReq   = dirReq[grantSel];
    assign holdDone = (timer >= HOLD_LAST);
    assign maxDone  = (timer >= MAX_LAST);

    always_comb begin
        nextState = state;
        nextTimer = timer;
        nextGrant = grantSel;
        nextLast  = lastDir;
        case (state)
            IDLE: begin
                if (idleFound) begin
                    nextState = CLEAR;
                    nextGrant = idleWinner;
                    nextTimer = '0;
                end
            end
            CLEAR: begin
                if (timer >= CLEAR_LAST) begin
                    nextState = GRANT;
                    nextTimer = '0;
                end else begin
                    nextTimer = timer + 1'b1;
                end
            end
            GRANT: begin
                if (timer < MAX_SAT) begin
                    nextTimer = timer + 1'b1;
                end
                // Released after the minimum hold, or forced out once MAX_GRANT is reached
                // while someone else is waiting.
                if (holdDone && !curReq) begin
                    nextLast = grantSel;
                    nextTimer = '0;
                    if (grantFound) begin
                        nextState = CLEAR;
                        nextGrant = grantWinner;
                    end else begin
                        nextState = IDLE;
                    end
                end else if (maxDone && curReq && grantFound) begin
                    nextLast  = grantSel;
                    nextTimer = '0;
                    nextState = CLEAR;
                    nextGrant = grantWinner;
                end
            end
            default: begin
                nextState = IDLE;
                nextTimer = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            reqReg   <= '0;
            timer    <= '0;
            grantSel <= '0;
            lastDir  <= LAST_INIT;
        end else begin
            reqReg   <= emergencyLane;
            state    <= nextState;
            timer    <= nextTimer;
            grantSel <= nextGrant;
            lastDir  <= nextLast;
        end
    end

    always_comb begin
        laneOutput = '0;
        for (int l = 0; l < NLANE; l++) begin
            if ((state == GRANT) && (DIR_W'(l / LANES_PER_DIR) == grantSel)) begin
                laneOutput[l] = 1'b1;
            end
        end
    end

    assign grantDir      = grantSel;
    assign preemptActive = (state != IDLE);
    assign clearing      = (state == CLEAR);

endmodule

// File: tb/tb_emergency_preempt.sv
// Table-driven scoreboard bench for emergency_preempt at default parameters.
module tb_emergency_preempt;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:7] emergencyLane;
    logic [0:7] laneOutput;
    logic [0:1] grantDir;
    logic       preemptActive;
    logic       clearing;

    typedef struct {
        logic       rst;
        logic [0:7] lanes;
        int         reps;
        logic [0:7] expLane;
        logic [0:1] expDir;
        logic       expAct;
        logic       expClr;
    } vec_t;

    typedef struct {
        int         id;
        logic [0:7] lane;
        logic [0:1] dir;
        logic       act;
        logic       clr;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];
    int   vectorCount = 0;
    int   missCount   = 0;

    emergency_preempt dut (
        .clk           (clk),
        .rst           (rst),
        .emergencyLane (emergencyLane),
        .laneOutput    (laneOutput),
        .grantDir      (grantDir),
        .preemptActive (preemptActive),
        .clearing      (clearing)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [0:7] lanes, int reps,
                                logic [0:7] expLane, int dir, logic act, logic clr);
        vec_t v;
        v.rst     = r;
        v.lanes   = lanes;
        v.reps    = reps;
        v.expLane = expLane;
        v.expDir  = 2'(dir);
        v.expAct  = act;
        v.expClr  = clr;
        return v;
    endfunction

    // Pops the oldest expectation and compares it with what the DUT shows now.
    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
        end else begin
            e = scoreboard.pop_front();
            vectorCount++;
            if (laneOutput !== e.lane || grantDir !== e.dir ||
                preemptActive !== e.act || clearing !== e.clr) begin
                missCount++;
                $display("[TB] FAIL vec%0d: got lane=%b dir=%0d act=%b clr=%b, required lane=%b dir=%0d act=%b clr=%b",
                         e.id, laneOutput, grantDir, preemptActive, clearing,
                         e.lane, e.dir, e.act, e.clr);
            end
        end
    endtask

    // Drives one record for its repeat count; expectation pushed with each drive.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        for (int r = 0; r < v.reps; r++) begin
            @(negedge clk);
            rst           = v.rst;
            emergencyLane = v.lanes;
            e.id   = vectorCount + scoreboard.size();
            e.lane = v.expLane;
            e.dir  = v.expDir;
            e.act  = v.expAct;
            e.clr  = v.expClr;
            scoreboard.push_back(e);
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic doReset();
        applyStimulus(mk(1'b1, 8'b0000_0000, 2, 8'b0000_0000, 0, 1'b0, 1'b0));
    endtask

    initial begin
        logic [0:7] pat;
        rst           = 1'b1;
        emergencyLane = '0;

        // Scenario 1: lane 3 held -> dir1 granted and kept indefinitely.
        vecs.push_back(mk(1'b1, 8'b0000_0000, 2,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0001_0000, 1,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0001_0000, 3,  8'b0000_0000, 1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b0001_0000, 40, 8'b0011_0000, 1, 1'b1, 1'b0));
        // Scenario 2: single-cycle pulse on lane 0 -> minimum hold then IDLE.
        vecs.push_back(mk(1'b1, 8'b0000_0000, 2,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_0000, 1,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0000_0000, 3,  8'b0000_0000, 0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b0000_0000, 8,  8'b1100_0000, 0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0000_0000, 3,  8'b0000_0000, 0, 1'b0, 1'b0));
        // Scenario 3: dir0 and dir2 both held -> forced hand-over after MAX_GRANT.
        vecs.push_back(mk(1'b1, 8'b0000_0000, 2,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_1000, 1,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_1000, 3,  8'b0000_0000, 0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b1000_1000, 32, 8'b1100_0000, 0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_1000, 3,  8'b0000_0000, 2, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b1000_1000, 5,  8'b0000_1100, 2, 1'b1, 1'b0));
        // Scenario 4: dir1 granted, dir3 and dir0 waiting -> dir3 then dir0.
        vecs.push_back(mk(1'b1, 8'b0000_0000, 2,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0010_0000, 1,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0010_0000, 3,  8'b0000_0000, 1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b0010_0000, 3,  8'b0011_0000, 1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1010_0010, 6,  8'b0011_0000, 1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_0010, 1,  8'b0011_0000, 1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_0010, 3,  8'b0000_0000, 3, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b1000_0010, 2,  8'b0000_0011, 3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_0000, 6,  8'b0000_0011, 3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b1000_0000, 3,  8'b0000_0000, 0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b1000_0000, 4,  8'b1100_0000, 0, 1'b1, 1'b0));
        // Request arriving during CLEAR does not disturb the chosen direction.
        vecs.push_back(mk(1'b1, 8'b0000_0000, 2,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0010_0000, 1,  8'b0000_0000, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0000_0011, 3,  8'b0000_0000, 1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b0000_0011, 8,  8'b0011_0000, 1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'b0000_0011, 3,  8'b0000_0000, 3, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'b0000_0011, 2,  8'b0000_0011, 3, 1'b1, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Scenario 5: reset mid-GRANT with request held, then full restart.
        doReset();
        applyStimulus(mk(1'b0, 8'b0010_0000, 1, 8'b0000_0000, 0, 1'b0, 1'b0));
        applyStimulus(mk(1'b0, 8'b0010_0000, 3, 8'b0000_0000, 1, 1'b1, 1'b1));
        applyStimulus(mk(1'b0, 8'b0010_0000, 4, 8'b0011_0000, 1, 1'b1, 1'b0));
        applyStimulus(mk(1'b1, 8'b0010_0000, 1, 8'b0000_0000, 0, 1'b0, 1'b0));
        applyStimulus(mk(1'b0, 8'b0010_0000, 1, 8'b0000_0000, 0, 1'b0, 1'b0));
        applyStimulus(mk(1'b0, 8'b0010_0000, 3, 8'b0000_0000, 1, 1'b1, 1'b1));
        applyStimulus(mk(1'b0, 8'b0010_0000, 3, 8'b0011_0000, 1, 1'b1, 1'b0));

        // Scenario 6: two lanes of dir1 behave exactly like one.
        for (int k = 0; k < 2; k++) begin
            pat = (k == 0) ? 8'b0011_0000 : 8'b0010_0000;
            doReset();
            applyStimulus(mk(1'b0, pat,         1,  8'b0000_0000, 0, 1'b0, 1'b0));
            applyStimulus(mk(1'b0, pat,         3,  8'b0000_0000, 1, 1'b1, 1'b1));
            applyStimulus(mk(1'b0, pat,         10, 8'b0011_0000, 1, 1'b1, 1'b0));
            applyStimulus(mk(1'b0, 8'b0000_0000, 1, 8'b0011_0000, 1, 1'b1, 1'b0));
            applyStimulus(mk(1'b0, 8'b0000_0000, 2, 8'b0000_0000, 1, 1'b0, 1'b0));
        end

        if (scoreboard.size() != 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", scoreboard.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
